// File: rtl/tile_chk_pkg.sv
// Shared types and defaults for the tile-grid signature checker.
package tile_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tile_state_e;

  localparam logic [15:0] SEED_DEFAULT = 16'hFFFF;
  localparam logic [15:0] POLY_DEFAULT = 16'h1021;

endpackage

// File: rtl/tile_misr.sv
// Combinational MISR step: shift the signature left, fold in the polynomial
// when the outgoing MSB is set, then XOR in the 4-bit tile response.
module tile_misr
  import tile_chk_pkg::*;
#(
  parameter int                 SIG_W = 16,
  parameter logic [SIG_W-1:0]   POLY  = POLY_DEFAULT
) (
  input  logic [SIG_W-1:0] sig,
  input  logic [3:0]       resp,
  input  logic             en,
  output logic [SIG_W-1:0] sig_next
);

  logic [SIG_W-1:0] shifted;

  // Next signature when en is high; otherwise the current signature passes through.
  always_comb begin
    shifted  = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0);
    sig_next = sig;
    if (en) begin
      sig_next = shifted ^ {{(SIG_W-4){1'b0}}, resp};
    end
  end

endmodule

// File: rtl/tile_sig_checker.sv
// Compacts a run of 4-bit tile-grid responses into a MISR signature and
// compares the final signature against a golden value.
//
// Handshake: a response transfers on a rising edge where resp_valid and
// resp_ready are both high. resp_ready is high exactly while busy (RUN), does
// not depend on resp_valid, and responses presented outside RUN are dropped.
module tile_sig_checker
  import tile_chk_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter int               CNT_W = 8,
  parameter logic [SIG_W-1:0] SEED  = SEED_DEFAULT,
  parameter logic [SIG_W-1:0] POLY  = POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vecs,
  input  logic [SIG_W-1:0] golden_sig,
  input  logic             resp_valid,
  input  logic [3:0]       resp,
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig,
  output logic [CNT_W-1:0] vec_count,
  output tile_state_e      state_dbg
);

  tile_state_e      state, state_next;
  logic [CNT_W-1:0] num_vecs_q;
  logic [SIG_W-1:0] sig_next;
  logic             xfer;
  logic             last_xfer;
  logic             start_acc;

  // start is only honoured outside RUN; a zero count goes straight to DONE.
  assign start_acc = start && (state != RUN);
  assign xfer      = (state == RUN) && resp_valid;
  assign last_xfer = xfer && (vec_count == num_vecs_q - 1'b1);

  tile_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .sig      (sig),
    .resp     (resp),
    .en       (xfer),
    .sig_next (sig_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    resp_ready = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          state_next = (num_vecs == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy       = 1'b1;
        resp_ready = 1'b1;
        if (last_xfer) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Signature, counter, latched run length and registered pass flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig        <= SEED;
      vec_count  <= '0;
      num_vecs_q <= '0;
      pass       <= 1'b0;
    end else if (start_acc) begin
      sig        <= SEED;
      vec_count  <= '0;
      num_vecs_q <= num_vecs;
      pass       <= (num_vecs == '0) ? (SEED == golden_sig) : 1'b0;
    end else if (xfer) begin
      sig       <= sig_next;
      vec_count <= vec_count + 1'b1;
      if (last_xfer) begin
        pass <= (sig_next == golden_sig);
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_tile_sig_checker.sv
// Directed bench for tile_sig_checker with a MISR reference model.
module tb_tile_sig_checker;
  import tile_chk_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  num_vecs;
  logic [15:0] golden_sig;
  logic        resp_valid;
  logic [3:0]  resp;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] sig;
  logic [7:0]  vec_count;
  tile_state_e state_dbg;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] model_sig;
  logic [15:0] exp_sig;
  logic [7:0]  exp_vc;
  logic [3:0]  long_resp[255];

  tile_sig_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_vecs   (num_vecs),
    .golden_sig (golden_sig),
    .resp_valid (resp_valid),
    .resp       (resp),
    .resp_ready (resp_ready),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .sig        (sig),
    .vec_count  (vec_count),
    .state_dbg  (state_dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [3:0] r);
    logic [15:0] t;
    t = {s[14:0], 1'b0};
    if (s[15]) t = t ^ 16'h1021;
    return t ^ {12'h000, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; returns 1ns after the rising edge so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       bp_valid[7];
    logic [3:0] bp_resp[7];

    rst_n      = 1'b0;
    start      = 1'b0;
    num_vecs   = 8'd0;
    golden_sig = 16'h0000;
    resp_valid = 1'b0;
    resp       = 4'h0;
    #12;

    // Reset state.
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", resp_ready, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_sig", sig, 16'hFFFF);
    check("rst_vc", vec_count, 8'd0);
    rst_n = 1'b1;
    tick();

    // Single vector, matching golden.
    start = 1'b1; num_vecs = 8'd1;
    tick();
    start = 1'b0;
    check("sv_busy", busy, 1'b1);
    check("sv_ready", resp_ready, 1'b1);
    check("sv_sig_seed", sig, 16'hFFFF);
    resp_valid = 1'b1; resp = 4'h0; golden_sig = 16'hEFDF;
    tick();
    resp_valid = 1'b0;
    check("sv_sig", sig, 16'hEFDF);
    check("sv_done", done, 1'b1);
    check("sv_pass", pass, 1'b1);
    check("sv_vc", vec_count, 8'd1);
    check("sv_ready_done", resp_ready, 1'b0);
    tick();
    check("sv_hold_done", done, 1'b1);
    check("sv_hold_pass", pass, 1'b1);

    // Mismatch, restarted from DONE.
    start = 1'b1; num_vecs = 8'd1;
    tick();
    start = 1'b0;
    check("mm_busy", busy, 1'b1);
    resp_valid = 1'b1; resp = 4'h0; golden_sig = 16'hEFDE;
    tick();
    resp_valid = 1'b0;
    check("mm_done", done, 1'b1);
    check("mm_pass", pass, 1'b0);
    check("mm_vc", vec_count, 8'd1);

    // Backpressure gaps with a start pulse during RUN.
    bp_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bp_resp  = '{4'h3, 4'hA, 4'h5, 4'hC, 4'h9, 4'h1, 4'h6};
    model_sig = 16'hFFFF;
    for (int i = 0; i < 7; i++) begin
      if (bp_valid[i]) model_sig = misr_ref(model_sig, bp_resp[i]);
    end
    golden_sig = model_sig;
    start = 1'b1; num_vecs = 8'd4;
    tick();
    start = 1'b0;
    exp_sig = 16'hFFFF;
    exp_vc  = 8'd0;
    for (int i = 0; i < 7; i++) begin
      resp_valid = bp_valid[i];
      resp       = bp_resp[i];
      if (i == 2) begin
        start = 1'b1; num_vecs = 8'd1;
      end
      tick();
      start = 1'b0;
      if (bp_valid[i]) begin
        exp_sig = misr_ref(exp_sig, bp_resp[i]);
        exp_vc  = exp_vc + 8'd1;
      end
      check($sformatf("bp_sig_%0d", i), sig, exp_sig);
      check($sformatf("bp_vc_%0d", i), vec_count, exp_vc);
      check($sformatf("bp_done_%0d", i), done, (exp_vc == 8'd4));
    end
    resp_valid = 1'b0;
    check("bp_pass", pass, 1'b1);
    check("bp_sig_model", sig, model_sig);

    // Reset in the middle of a run.
    start = 1'b1; num_vecs = 8'd8;
    tick();
    start = 1'b0;
    resp_valid = 1'b1; resp = 4'h7;
    repeat (3) tick();
    check("mr_vc_before", vec_count, 8'd3);
    rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 1'b0);
    check("mr_ready", resp_ready, 1'b0);
    check("mr_sig", sig, 16'hFFFF);
    check("mr_vc", vec_count, 8'd0);
    #2;
    rst_n = 1'b1;
    repeat (2) tick();
    check("mr_idle_busy", busy, 1'b0);
    check("mr_idle_done", done, 1'b0);
    check("mr_idle_sig", sig, 16'hFFFF);
    check("mr_idle_vc", vec_count, 8'd0);
    resp_valid = 1'b0;

    // Zero-length run from IDLE; resp_valid held high and ignored.
    resp_valid = 1'b1; resp = 4'hF;
    start = 1'b1; num_vecs = 8'd0; golden_sig = 16'hFFFF;
    check("zl_ready_pre", resp_ready, 1'b0);
    tick();
    start = 1'b0;
    check("zl_done", done, 1'b1);
    check("zl_pass", pass, 1'b1);
    check("zl_ready", resp_ready, 1'b0);
    check("zl_sig", sig, 16'hFFFF);
    check("zl_vc", vec_count, 8'd0);
    resp_valid = 1'b0;

    // Long run of 255 random responses, restarted from DONE.
    model_sig = 16'hFFFF;
    for (int i = 0; i < 255; i++) begin
      long_resp[i] = 4'($urandom_range(0, 15));
      model_sig    = misr_ref(model_sig, long_resp[i]);
      exp_q.push_back(model_sig);
    end
    golden_sig = model_sig;
    start = 1'b1; num_vecs = 8'd255;
    tick();
    start = 1'b0;
    for (int i = 0; i < 255; i++) begin
      resp_valid = 1'b1;
      resp       = long_resp[i];
      tick();
      exp_sig = exp_q.pop_front();
      check($sformatf("lr_sig_%0d", i), sig, exp_sig);
    end
    resp_valid = 1'b0;
    check("lr_vc", vec_count, 8'd255);
    check("lr_done", done, 1'b1);
    check("lr_pass", pass, 1'b1);

    // Responses after DONE are ignored.
    resp_valid = 1'b1; resp = 4'h5;
    tick();
    resp_valid = 1'b0;
    check("post_sig", sig, model_sig);
    check("post_vc", vec_count, 8'd255);
    check("post_done", done, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
